// File: rtl/vga_box_painter.sv
// Pixel-colour generator: up to NUM_BOXES prioritised filled rectangles with optional per-frame bounce.
// Two-stage pipeline: per-box hit vector, then priority-selected colour and hit index.
module vga_box_painter #(
    parameter int NUM_BOXES = 4,
    parameter int COORD_W   = 10,
    parameter int COLOR_W   = 10,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BG_R      = 1,
    parameter int BG_G      = 3,
    parameter int BG_B      = 7
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic               iFrame_Start,
    input  logic               iWr_En,
    input  logic [3:0]         iWr_Box,
    input  logic [2:0]         iWr_Addr,
    input  logic [15:0]        iWr_Data,
    output logic [COLOR_W-1:0] oRed,
    output logic [COLOR_W-1:0] oGreen,
    output logic [COLOR_W-1:0] oBlue,
    output logic               oHit,
    output logic [3:0]         oHit_Idx
);
    localparam int MW = COORD_W + 4;
    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

    logic [COORD_W-1:0]        x_q [NUM_BOXES], x_d [NUM_BOXES];
    logic [COORD_W-1:0]        y_q [NUM_BOXES], y_d [NUM_BOXES];
    logic [COORD_W-1:0]        w_q [NUM_BOXES], w_d [NUM_BOXES];
    logic [COORD_W-1:0]        h_q [NUM_BOXES], h_d [NUM_BOXES];
    logic [COLOR_W-1:0]        r_q [NUM_BOXES], r_d [NUM_BOXES];
    logic [COLOR_W-1:0]        g_q [NUM_BOXES], g_d [NUM_BOXES];
    logic [COLOR_W-1:0]        b_q [NUM_BOXES], b_d [NUM_BOXES];
    logic signed [3:0]         dx_q[NUM_BOXES], dx_d[NUM_BOXES];
    logic signed [3:0]         dy_q[NUM_BOXES], dy_d[NUM_BOXES];
    logic [NUM_BOXES-1:0]      en_q, en_d, mv_q, mv_d;
    logic [MW-1:0]             mvx_s[NUM_BOXES], mvy_s[NUM_BOXES];
    logic [NUM_BOXES-1:0]      hit_q, hit_d;
    logic [COLOR_W-1:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                      ohit_q, ohit_d;
    logic [3:0]                idx_q, idx_d;

    // Negating -8 has no 4-bit representation, so it saturates to +7.
    function automatic logic signed [3:0] neg_sat(input logic signed [3:0] v);
        logic signed [3:0] res;
        if (v == 4'sb1000) res = 4'sb0111;
        else               res = -v;
        return res;
    endfunction

    // Returns {new_velocity, new_position} for one axis, reflecting off 0 and limit.
    function automatic logic [MW-1:0] move_axis(input logic [COORD_W-1:0] pos,
                                                 input logic [COORD_W-1:0] size,
                                                 input logic signed [3:0]  vel,
                                                 input logic [COORD_W-1:0] limit);
        logic signed [COORD_W+1:0] np;
        logic signed [COORD_W+1:0] far;
        logic [MW-1:0]             res;
        np  = $signed({2'b00, pos}) + $signed({{(COORD_W-2){vel[3]}}, vel});
        far = np + $signed({2'b00, size});
        if (np[COORD_W+1])                      res = {neg_sat(vel), {COORD_W{1'b0}}};
        else if (far > $signed({2'b00, limit})) res = {neg_sat(vel), limit - size};
        else                                    res = {vel, np[COORD_W-1:0]};
        return res;
    endfunction

    function automatic logic [COORD_W-1:0] clamp(input logic [15:0] d, input logic [COORD_W-1:0] lim);
        logic [COORD_W-1:0] res;
        if (d > {{(16-COORD_W){1'b0}}, lim}) res = lim;
        else                                 res = d[COORD_W-1:0];
        return res;
    endfunction

    // Candidate motion results for every box, used only on iFrame_Start.
    always_comb begin
        for (int i = 0; i < NUM_BOXES; i++) begin
            mvx_s[i] = move_axis(x_q[i], w_q[i], dx_q[i], H_LIM);
            mvy_s[i] = move_axis(y_q[i], h_q[i], dy_q[i], V_LIM);
        end
    end

    // Register-file next state: motion first, then a same-cycle write overrides its field.
    always_comb begin
        logic [3:0] wr_sel;
        en_d = en_q;
        mv_d = mv_q;
        for (int i = 0; i < NUM_BOXES; i++) begin
            w_d[i] = w_q[i];
            h_d[i] = h_q[i];
            r_d[i] = r_q[i];
            g_d[i] = g_q[i];
            b_d[i] = b_q[i];
            if (iFrame_Start && en_q[i] && mv_q[i]) begin
                x_d[i]  = mvx_s[i][COORD_W-1:0];
                dx_d[i] = mvx_s[i][MW-1:COORD_W];
                y_d[i]  = mvy_s[i][COORD_W-1:0];
                dy_d[i] = mvy_s[i][MW-1:COORD_W];
            end else begin
                x_d[i]  = x_q[i];
                dx_d[i] = dx_q[i];
                y_d[i]  = y_q[i];
                dy_d[i] = dy_q[i];
            end
            wr_sel = {iWr_En && (iWr_Box == 4'(i)), iWr_Addr};
            case (wr_sel)
                4'b1000: x_d[i] = iWr_Data[COORD_W-1:0];
                4'b1001: y_d[i] = iWr_Data[COORD_W-1:0];
                4'b1010: w_d[i] = clamp(iWr_Data, H_LIM);
                4'b1011: h_d[i] = clamp(iWr_Data, V_LIM);
                4'b1100: r_d[i] = iWr_Data[COLOR_W-1:0];
                4'b1101: g_d[i] = iWr_Data[COLOR_W-1:0];
                4'b1110: b_d[i] = iWr_Data[COLOR_W-1:0];
                4'b1111: begin
                    en_d[i] = iWr_Data[0];
                    mv_d[i] = iWr_Data[1];
                    dx_d[i] = iWr_Data[7:4];
                    dy_d[i] = iWr_Data[11:8];
                end
                default: wr_sel = 4'b0000;
            endcase
        end
    end

    // Stage 1: per-box hit test; sums carry one extra bit so they never wrap.
    always_comb begin
        for (int i = 0; i < NUM_BOXES; i++) begin
            hit_d[i] = en_q[i]
                && ({1'b0, iX} >= {1'b0, x_q[i]}) && ({1'b0, iX} < ({1'b0, x_q[i]} + {1'b0, w_q[i]}))
                && ({1'b0, iY} >= {1'b0, y_q[i]}) && ({1'b0, iY} < ({1'b0, y_q[i]} + {1'b0, h_q[i]}));
        end
    end

    // Stage 2: lowest-index hitting box wins, otherwise background.
    always_comb begin
        logic found;
        found   = 1'b0;
        red_d   = COLOR_W'(BG_R);
        green_d = COLOR_W'(BG_G);
        blue_d  = COLOR_W'(BG_B);
        ohit_d  = 1'b0;
        idx_d   = 4'd0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            if (hit_q[i] && !found) begin
                found   = 1'b1;
                red_d   = r_q[i];
                green_d = g_q[i];
                blue_d  = b_q[i];
                ohit_d  = 1'b1;
                idx_d   = 4'(i);
            end else begin
                found = found;
            end
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                x_q[i]  <= {COORD_W{1'b0}};
                y_q[i]  <= {COORD_W{1'b0}};
                w_q[i]  <= {COORD_W{1'b0}};
                h_q[i]  <= {COORD_W{1'b0}};
                r_q[i]  <= {COLOR_W{1'b0}};
                g_q[i]  <= {COLOR_W{1'b0}};
                b_q[i]  <= {COLOR_W{1'b0}};
                dx_q[i] <= 4'sb0000;
                dy_q[i] <= 4'sb0000;
            end
            en_q    <= {NUM_BOXES{1'b0}};
            mv_q    <= {NUM_BOXES{1'b0}};
            hit_q   <= {NUM_BOXES{1'b0}};
            red_q   <= COLOR_W'(BG_R);
            green_q <= COLOR_W'(BG_G);
            blue_q  <= COLOR_W'(BG_B);
            ohit_q  <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            en_q    <= en_d;
            mv_q    <= mv_d;
            hit_q   <= hit_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            ohit_q  <= ohit_d;
            idx_q   <= idx_d;
        end
    end

    assign oRed     = red_q;
    assign oGreen   = green_q;
    assign oBlue    = blue_q;
    assign oHit     = ohit_q;
    assign oHit_Idx = idx_q;
endmodule

// File: tb/tb_vga_box_painter.sv
// Directed bench for vga_box_painter: expected pixels are queued when driven and checked two edges later.
module tb_vga_box_painter;
    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [9:0]  iX = 10'd0, iY = 10'd0;
    logic        iFrame_Start = 1'b0;
    logic        iWr_En = 1'b0;
    logic [3:0]  iWr_Box = 4'd0;
    logic [2:0]  iWr_Addr = 3'd0;
    logic [15:0] iWr_Data = 16'd0;
    logic [9:0]  oRed, oGreen, oBlue;
    logic        oHit;
    logic [3:0]  oHit_Idx;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        bit         chk;
        int         tag;
        logic [9:0] r, g, b;
        logic       hit;
        logic [3:0] idx;
    } exp_t;
    exp_t sb[$];

    vga_box_painter dut (
        .iCLK(iCLK), .iRST(iRST), .iX(iX), .iY(iY), .iFrame_Start(iFrame_Start),
        .iWr_En(iWr_En), .iWr_Box(iWr_Box), .iWr_Addr(iWr_Addr), .iWr_Data(iWr_Data),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oHit(oHit), .oHit_Idx(oHit_Idx)
    );

    always #5 iCLK = ~iCLK;

    task automatic compare(input int tag, input logic [9:0] r, g, b, input logic hit, input logic [3:0] idx);
        compared++;
        assert ({oRed, oGreen, oBlue, oHit, oHit_Idx} === {r, g, b, hit, idx}) else begin
            mismatched++;
            $error("FAIL pix%0d: got rgb=%h/%h/%h hit=%b idx=%0d, expected rgb=%h/%h/%h hit=%b idx=%0d",
                   tag, oRed, oGreen, oBlue, oHit, oHit_Idx, r, g, b, hit, idx);
        end
    endtask

    // One clock: push this cycle's expectation, then check the entry whose result has just appeared.
    task automatic tick(input bit chk, input int tag, input logic [9:0] r, g, b, input logic hit, input logic [3:0] idx);
        exp_t e;
        e.chk = chk; e.tag = tag; e.r = r; e.g = g; e.b = b; e.hit = hit; e.idx = idx;
        sb.push_back(e);
        @(posedge iCLK); #1;
        if (sb.size() > 1) begin
            e = sb.pop_front();
            if (e.chk) compare(e.tag, e.r, e.g, e.b, e.hit, e.idx);
        end
    endtask

    task automatic idle();
        tick(1'b0, 0, 10'd0, 10'd0, 10'd0, 1'b0, 4'd0);
    endtask

    task automatic wr(input int box, input int addr, input int data);
        iWr_En = 1'b1; iWr_Box = box[3:0]; iWr_Addr = addr[2:0]; iWr_Data = data[15:0];
        idle();
        iWr_En = 1'b0;
    endtask

    task automatic set_box(input int box, input int x, y, w, h, r, g, b, ctrl);
        wr(box, 0, x); wr(box, 1, y); wr(box, 2, w); wr(box, 3, h);
        wr(box, 4, r); wr(box, 5, g); wr(box, 6, b); wr(box, 7, ctrl);
    endtask

    task automatic frame();
        iFrame_Start = 1'b1;
        idle();
        iFrame_Start = 1'b0;
    endtask

    task automatic pbg(input int tag, input int x, y);
        iX = x[9:0]; iY = y[9:0];
        tick(1'b1, tag, 10'd1, 10'd3, 10'd7, 1'b0, 4'd0);
    endtask

    task automatic phit(input int tag, input int x, y, r, g, b, idx);
        iX = x[9:0]; iY = y[9:0];
        tick(1'b1, tag, r[9:0], g[9:0], b[9:0], 1'b1, idx[3:0]);
    endtask

    // Box1 (green 0x155) horizontal span check at row 305: X-1 miss, X and X+9 hit, X+10 miss.
    task automatic span1(input int tag, input int x);
        if (x > 0) pbg(tag, x - 1, 305);
        else       pbg(tag, x + 200, 305);
        phit(tag + 1, x, 305, 0, 'h155, 0, 1);
        phit(tag + 2, x + 9, 305, 0, 'h155, 0, 1);
        pbg(tag + 3, x + 10, 305);
    endtask

    initial begin
        iRST = 1'b1;
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        compare(1, 10'd1, 10'd3, 10'd7, 1'b0, 4'd0);
        iRST = 1'b0;

        // Sparse sweep of the screen with every box disabled.
        for (int y = 0; y < 480; y += 53)
            for (int x = 0; x < 640; x += 71)
                pbg(10, x, y);
        pbg(11, 639, 479);
        pbg(12, 0, 0);

        // Box0 white square: inclusive left/top, exclusive right/bottom.
        set_box(0, 220, 140, 200, 200, 'hF, 'hF, 'hF, 1);
        phit(20, 220, 140, 'hF, 'hF, 'hF, 0);
        phit(21, 419, 339, 'hF, 'hF, 'hF, 0);
        pbg(22, 219, 140);
        pbg(23, 420, 200);
        pbg(24, 220, 139);
        pbg(25, 419, 340);

        // Box3 size clamps and zero width.
        set_box(3, 0, 400, 'hFFFF, 10, 1, 2, 3, 1);
        phit(30, 639, 405, 1, 2, 3, 3);
        phit(31, 0, 405, 1, 2, 3, 3);
        pbg(32, 700, 405);
        wr(3, 3, 'hFFFF);
        phit(33, 5, 879, 1, 2, 3, 3);
        pbg(34, 5, 880);
        wr(3, 2, 0);
        pbg(35, 0, 405);
        wr(3, 7, 0);

        // Overlap priority, then out-of-range box index is ignored.
        set_box(0, 100, 100, 50, 50, 'h3FF, 0, 0, 1);
        set_box(2, 120, 120, 50, 50, 0, 0, 'h3FF, 1);
        phit(40, 130, 130, 'h3FF, 0, 0, 0);
        phit(41, 160, 160, 0, 0, 'h3FF, 2);
        wr(0, 7, 0);
        phit(42, 130, 130, 0, 0, 'h3FF, 2);
        wr(2, 7, 0);
        pbg(43, 130, 130);
        wr(4, 7, 1);
        pbg(44, 130, 130);

        // Box1 bouncing off the left and right edges.
        set_box(1, 3, 300, 10, 10, 0, 'h155, 0, 'h0C3);
        frame();
        span1(50, 0);
        frame();
        span1(60, 4);
        wr(1, 0, 628);
        wr(1, 7, 'h073);
        frame();
        span1(70, 630);
        frame();
        span1(80, 623);

        // dx = -8 at the left edge saturates to +7 on reflection.
        wr(1, 0, 2);
        wr(1, 7, 'h083);
        frame();
        span1(90, 0);
        frame();
        span1(100, 7);

        // Write to X coincides with iFrame_Start: X takes the write, Y still moves.
        wr(1, 0, 100);
        wr(1, 7, 'h243);
        iWr_En = 1'b1; iWr_Box = 4'd1; iWr_Addr = 3'd0; iWr_Data = 16'd50;
        frame();
        iWr_En = 1'b0;
        span1(110, 50);
        pbg(120, 55, 301);
        phit(121, 55, 302, 0, 'h155, 0, 1);
        phit(122, 55, 311, 0, 'h155, 0, 1);
        pbg(123, 55, 312);

        // Reset with the pipeline full of hits.
        iX = 10'd55; iY = 10'd305;
        idle(); idle(); idle();
        iRST = 1'b1;
        @(posedge iCLK); #1;
        compare(130, 10'd1, 10'd3, 10'd7, 1'b0, 4'd0);
        sb.delete();
        iRST = 1'b0;
        @(posedge iCLK); #1;
        compare(131, 10'd1, 10'd3, 10'd7, 1'b0, 4'd0);
        pbg(132, 55, 305);
        pbg(133, 55, 305);
        pbg(134, 0, 0);
        wr(1, 7, 1);
        pbg(135, 0, 0);
        pbg(136, 55, 305);
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
